sprite_engine: RTL and testbench

Parametrised multi-sprite movement and pixel-plotting engine for the 160x120 VGA game, replacing the single-player datapath/control pair. Holds position and velocity for NUM_SPRITES sprites:
- Sprite 0 is the player, steered by the KEY buttons.
- All other sprites (bees) move autonomously and bounce off screen edges.

On every frame tick it erases, moves and redraws each enabled sprite in turn. The result is a one-pixel-per-cycle stream for the VGA adapter.

---
 rtl/sprite_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_sprite_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - multi-sprite erase/move/draw engine emitting one pixel per cycle
// Define SPRITE_COLLIDE_EN to add the player/bee overlap outputs hit and hit_id.
module sprite_engine #(
  parameter int         NUM_SPRITES = 4,
  parameter int         COORD_W     = 8,
  parameter int         X_MAX       = 159,
  parameter int         Y_MAX       = 119,
  parameter int         SIZE        = 4,
  parameter int         RATE_W      = 28,
  parameter logic [2:0] BG_COLOR    = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [RATE_W-1:0]        rate,
  input  logic [3:0]               dir_in,
  input  logic [NUM_SPRITES-1:0]   sprite_en,
  input  logic [3*NUM_SPRITES-1:0] sprite_color,
  input  logic                     load_en,
  input  logic [3:0]               load_id,
  input  logic [COORD_W-1:0]       load_x,
  input  logic [COORD_W-1:0]       load_y,
  input  logic [1:0]               load_vx,
  input  logic [1:0]               load_vy,
  output logic [COORD_W-1:0]       x_out,
  output logic [COORD_W-1:0]       y_out,
  output logic [2:0]               color_out,
  output logic                     writeEn,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic                     hit,
  output logic [3:0]               hit_id
`endif
);

  localparam logic [COORD_W-1:0] XL   = COORD_W'(X_MAX - SIZE + 1);
  localparam logic [COORD_W-1:0] YL   = COORD_W'(Y_MAX - SIZE + 1);
  localparam logic [2:0]         LAST = 3'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, NEXT} state_t;

  state_t               state, state_d;
  logic [3:0]           id, id_d;
  logic [2:0]           col, row, col_d, row_d, col_inc, row_inc;
  logic [RATE_W-1:0]    div;
  logic                 tick, pending, start, load_ok, pix_last, en_next;
  logic [COORD_W-1:0]   px [NUM_SPRITES];
  logic [COORD_W-1:0]   py [NUM_SPRITES];
  logic [1:0]           vx [NUM_SPRITES];
  logic [1:0]           vy [NUM_SPRITES];
  logic [COORD_W-1:0]   cur_x, cur_y, new_x, new_y, sel_x, sel_y, pos_x, pos_y;
  logic [1:0]           cur_vx, cur_vy, new_vx, new_vy;
  logic [2:0]           sel_color, color_d;
  logic                 we_d;

  // Returns {velocity, position}; the bounce is decided before the step is applied.
  function automatic logic [COORD_W+1:0] bee_step(input logic [COORD_W-1:0] p,
                                                  input logic [1:0] v,
                                                  input logic [COORD_W-1:0] lim);
    logic [1:0]         nv;
    logic [COORD_W-1:0] np;
    nv = v;
    if (v == 2'b01 && p == lim) nv = 2'b11;
    else if (v == 2'b11 && p == '0) nv = 2'b01;
    case (nv)
      2'b01:   np = p + COORD_W'(1);
      2'b11:   np = p - COORD_W'(1);
      default: np = p;
    endcase
    return {nv, np};
  endfunction

  function automatic logic [COORD_W-1:0] player_step(input logic [COORD_W-1:0] p,
                                                     input logic inc, input logic dec,
                                                     input logic [COORD_W-1:0] lim);
    if (inc && !dec && p < lim) return p + COORD_W'(1);
    if (dec && !inc && p != '0) return p - COORD_W'(1);
    return p;
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign tick    = (div == rate);
  assign start   = (state == IDLE) && (tick || pending);
  assign load_ok = (state == IDLE) && !tick && !pending && load_en;
  assign busy    = (state != IDLE);

  always_comb begin
    cur_x = '0; cur_y = '0; cur_vx = '0; cur_vy = '0; en_next = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (id == 4'(i)) begin
        cur_x = px[i]; cur_y = py[i]; cur_vx = vx[i]; cur_vy = vy[i];
      end
      if (id + 4'd1 == 4'(i)) en_next = sprite_en[i];
    end
  end

  always_comb begin
    {new_vx, new_x} = bee_step(cur_x, cur_vx, XL);
    {new_vy, new_y} = bee_step(cur_y, cur_vy, YL);
    if (id == 4'd0) begin
      new_x  = player_step(cur_x, ~dir_in[0], ~dir_in[1], XL);
      new_y  = player_step(cur_y, ~dir_in[2], ~dir_in[3], YL);
      new_vx = cur_vx;
      new_vy = cur_vy;
    end
  end

  always_comb begin
    state_d    = state;
    id_d       = id;
    col_d      = col;
    row_d      = row;
    frame_done = 1'b0;
    pix_last   = (col == LAST) && (row == LAST);
    col_inc    = col + 3'd1;
    row_inc    = row;
    if (col == LAST) begin
      col_inc = '0;
      row_inc = row + 3'd1;
    end
    case (state)
      IDLE: if (tick || pending) begin
        id_d    = '0;
        col_d   = '0;
        row_d   = '0;
        state_d = sprite_en[0] ? ERASE : NEXT;
      end
      ERASE, DRAW: begin
        if (pix_last) begin
          col_d   = '0;
          row_d   = '0;
          state_d = (state == ERASE) ? MOVE : NEXT;
        end else begin
          col_d = col_inc;
          row_d = row_inc;
        end
      end
      MOVE: state_d = DRAW;
      NEXT: begin
        if (id == 4'(NUM_SPRITES - 1)) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end else begin
          id_d    = id + 4'd1;
          state_d = en_next ? ERASE : NEXT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel registers are loaded with the pixel of the state being entered, so they stay in step with the FSM.
  always_comb begin
    sel_x = '0; sel_y = '0; sel_color = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (id_d == 4'(i)) begin
        sel_x = px[i]; sel_y = py[i]; sel_color = sprite_color[3*i +: 3];
      end
    end
    pos_x   = (state == MOVE) ? new_x : sel_x;
    pos_y   = (state == MOVE) ? new_y : sel_y;
    we_d    = (state_d == ERASE) || (state_d == DRAW);
    color_d = (state_d == ERASE) ? BG_COLOR : sel_color;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      id        <= '0;
      col       <= '0;
      row       <= '0;
      div       <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      writeEn   <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px[i] <= '0; py[i] <= '0; vx[i] <= '0; vy[i] <= '0;
      end
    end else begin
      state     <= state_d;
      id        <= id_d;
      col       <= col_d;
      row       <= row_d;
      div       <= tick ? '0 : div + RATE_W'(1);
      writeEn   <= we_d;
      x_out     <= we_d ? pos_x + COORD_W'(col_d) : '0;
      y_out     <= we_d ? pos_y + COORD_W'(row_d) : '0;
      color_out <= we_d ? color_d : '0;
      if (state == IDLE) pending <= pending && tick;
      else if (tick) begin
        if (pending) overrun <= 1'b1;
        else pending <= 1'b1;
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (state == MOVE && id == 4'(i)) begin
          px[i] <= new_x; py[i] <= new_y; vx[i] <= new_vx; vy[i] <= new_vy;
        end else if (load_ok && load_id == 4'(i)) begin
          px[i] <= clamp(load_x, XL);
          py[i] <= clamp(load_y, YL);
          if (i != 0) begin
            vx[i] <= load_vx; vy[i] <= load_vy;
          end
        end
      end
    end
  end

`ifdef SPRITE_COLLIDE_EN
  localparam logic [COORD_W:0] SZ = (COORD_W+1)'(SIZE);
  logic             hit_seen, cur_en, overlap;
  logic [COORD_W:0] ax, ay, bx, by;

  always_comb begin
    cur_en = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) if (id == 4'(i)) cur_en = sprite_en[i];
    ax      = {1'b0, px[0]};
    ay      = {1'b0, py[0]};
    bx      = {1'b0, cur_x};
    by      = {1'b0, cur_y};
    overlap = (bx < ax + SZ) && (ax < bx + SZ) && (by < ay + SZ) && (ay < by + SZ);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit      <= 1'b0;
      hit_id   <= '0;
      hit_seen <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (start) hit_seen <= 1'b0;
      else if (state == NEXT && id != 4'd0 && cur_en && overlap && !hit_seen) begin
        hit      <= 1'b1;
        hit_id   <= id;
        hit_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - directed self-checking bench for sprite_engine
// Define SPRITE_COLLIDE_EN to also exercise hit/hit_id.
module tb_sprite_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [27:0] rate;
  logic [3:0]  dir_in;
  logic [3:0]  sprite_en;
  logic [11:0] sprite_color;
  logic        load_en;
  logic [3:0]  load_id;
  logic [7:0]  load_x, load_y;
  logic [1:0]  load_vx, load_vy;
  logic [7:0]  x_out, y_out;
  logic [2:0]  color_out;
  logic        writeEn, busy, frame_done, overrun;
`ifdef SPRITE_COLLIDE_EN
  logic        hit;
  logic [3:0]  hit_id;
  int          h0;
`endif

  int n_chk = 0, n_pass = 0;
  int n, wr;
  int fx[4], fy[4], lx[4], ly[4], pc[4];
  int f_fx[4], f_fy[4], f_lx[4], f_ly[4], f_pix[4];
  int wr_cnt = 0, len = 0, f_wr = 0, f_len = 0, hit_cnt = 0;

  always #5 clk = ~clk;

  sprite_engine dut (
    .clk(clk), .reset_n(reset_n), .rate(rate), .dir_in(dir_in),
    .sprite_en(sprite_en), .sprite_color(sprite_color),
    .load_en(load_en), .load_id(load_id), .load_x(load_x), .load_y(load_y),
    .load_vx(load_vx), .load_vy(load_vy),
    .x_out(x_out), .y_out(y_out), .color_out(color_out), .writeEn(writeEn),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
`ifdef SPRITE_COLLIDE_EN
    , .hit(hit), .hit_id(hit_id)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 3000);
    check("frame_done_seen", int'(frame_done), 1);
    #1;
  endtask

  task automatic load_sprite(input int id, input int x, input int y,
                             input logic [1:0] vx, input logic [1:0] vy);
    @(negedge clk);
    load_id = 4'(id);
    load_x  = 8'(x);
    load_y  = 8'(y);
    load_vx = vx;
    load_vy = vy;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Per-frame pixel capture; sprite i is drawn in colour i+1, erase colour is 0.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_cnt = 0;
      len    = 0;
      for (int i = 0; i < 4; i++) pc[i] = 0;
    end else begin
      if (busy) len++;
      if (writeEn) begin
        wr_cnt++;
        for (int i = 0; i < 4; i++) begin
          if (color_out == 3'(i + 1)) begin
            if (pc[i] == 0) begin
              fx[i] = int'(x_out);
              fy[i] = int'(y_out);
            end
            lx[i] = int'(x_out);
            ly[i] = int'(y_out);
            pc[i]++;
          end
        end
      end
      if (frame_done) begin
        f_fx = fx; f_fy = fy; f_lx = lx; f_ly = ly; f_pix = pc;
        f_wr = wr_cnt; f_len = len;
        wr_cnt = 0;
        len    = 0;
        for (int i = 0; i < 4; i++) pc[i] = 0;
      end
    end
`ifdef SPRITE_COLLIDE_EN
    if (hit) hit_cnt++;
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; rate = 28'd9; dir_in = 4'hF; sprite_en = 4'hF;
    sprite_color = {3'd4, 3'd3, 3'd2, 3'd1};
    load_en = 1'b0; load_id = '0; load_x = '0; load_y = '0; load_vx = '0; load_vy = '0;
    repeat (3) @(negedge clk);
    check("rst_we", int'(writeEn), 0);
    check("rst_xy", int'({x_out, y_out}), 0);
    check("rst_color", int'(color_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);

    // First frame with rate=9: tick in cycle 10, first pixel in cycle 11, frame_done in cycle 146.
    reset_n = 1'b1;
    n = 1;
    while (!writeEn && n < 100) begin @(negedge clk); n++; end
    check("first_we_cycle", n, 11);
    check("first_we_color", int'(color_out), 0);
    check("first_we_xy", int'({x_out, y_out}), 0);
    while (!frame_done && n < 400) begin @(negedge clk); n++; end
    check("frame_done_cycle", n, 146);
    #1;
    check("f1_writes", f_wr, 128);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f1_pos%0d", i), f_fx[i] * 256 + f_fy[i], 0);
      check($sformatf("f1_pix%0d", i), f_pix[i], 16);
    end
    check("f1_overrun", int'(overrun), 1);
    @(negedge clk);
    check("busy_drop", int'(busy), 0);
    @(negedge clk);
    check("pending_start_busy", int'(busy), 1);
    check("pending_start_we", int'(writeEn), 1);

    // Reset in the middle of the pending frame.
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    rate = 28'd199;
    @(negedge clk);
    check("mid_rst_we", int'(writeEn), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr = 0;
    repeat (50) begin @(negedge clk); if (writeEn) wr++; end
    check("post_rst_quiet", wr, 0);

    // Bee bounce at XL = 156.
    load_sprite(1, 155, 50, 2'b01, 2'b00);
    wait_frame();
    check("bee_len", f_len, 136);
    check("bee_x1", f_fx[1], 156);
    check("bee_y1", f_fy[1], 50);
    check("bee_last_x", f_lx[1], 159);
    check("bee_last_y", f_ly[1], 53);
    wait_frame();
    check("bee_x2", f_fx[1], 155);
    wait_frame();
    check("bee_x3", f_fx[1], 154);

    // Player steering and load clamping.
    load_sprite(3, 200, 200, 2'b00, 2'b00);
    dir_in = 4'b0101;
    wait_frame();
    check("player_lu_x", f_fx[0], 0);
    check("player_lu_y", f_fy[0], 0);
    check("clamp_x", f_fx[3], 156);
    check("clamp_y", f_fy[3], 116);
    dir_in = 4'b1110;
    wait_frame();
    check("player_r_x", f_fx[0], 1);
    check("player_r_y", f_fy[0], 0);
    dir_in = 4'b1011;
    wait_frame();
    check("player_d_y", f_fy[0], 1);
    dir_in = 4'hF;

    // Partial enable.
    sprite_en = 4'b0101;
    wait_frame();
    check("en_len", f_len, 70);
    check("en_pix1", f_pix[1], 0);
    check("en_pix3", f_pix[3], 0);
    check("en_pix0", f_pix[0], 16);
    check("en_writes", f_wr, 64);
    sprite_en = 4'hF;

    // rate=0: ticks every cycle, loads while busy are ignored.
    @(negedge clk);
    reset_n = 1'b0;
    rate = 28'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    load_sprite(2, 50, 60, 2'b00, 2'b00);
    wait_frame();
    check("r0_overrun", int'(overrun), 1);
    wait_frame();
    check("r0_len", f_len, 136);
    check("busy_load_x", f_fx[2], 0);
    check("busy_load_y", f_fy[2], 0);

`ifdef SPRITE_COLLIDE_EN
    @(negedge clk);
    reset_n = 1'b0;
    rate = 28'd199;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load_sprite(0, 10, 10, 2'b00, 2'b00);
    load_sprite(2, 12, 10, 2'b00, 2'b00);
    h0 = hit_cnt;
    wait_frame();
    check("hit_count1", hit_cnt - h0, 1);
    check("hit_id1", int'(hit_id), 2);
    h0 = hit_cnt;
    wait_frame();
    check("hit_count2", hit_cnt - h0, 1);
    check("hit_id2", int'(hit_id), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
